// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: hands multiply/divide requests from the control unit to
// the iterative mult/div units, stalls the control unit while a unit runs,
// and captures results into the architectural HI/LO registers. Divide-by-zero
// is caught before the divider is started; a unit that never answers within
// MAX_CYCLES run cycles raises a timeout exception. Every output is a flop.
module muldiv_sequencer #(
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        multOp,
    input  logic        divOp,
    input  logic [31:0] divisor,
    input  logic        mult_done,
    input  logic        div_done,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    output logic        mult_start,
    output logic        div_start,
    output logic        busy,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        hilo_write,
    output logic        div_zero_exc,
    output logic        timeout_exc
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MULT_RUN = 3'd1,
        DIV_RUN  = 3'd2,
        WRITE    = 3'd3,
        EXC      = 3'd4
    } state_t;

    // Last counter value at which a done is still accepted; one more cycle
    // without a done is a timeout.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             mult_start_q, mult_start_d;
    logic             div_start_q, div_start_d;
    logic             busy_q, busy_d;
    logic             hilo_write_q, hilo_write_d;
    logic             div_zero_exc_q, div_zero_exc_d;
    logic             timeout_exc_q, timeout_exc_d;

    // Done/result of whichever unit is currently running. The start-pulse
    // cycle masks done so a stale pulse from a previous op cannot complete
    // the new one; the other unit's done is never looked at.
    logic        run_done;
    logic [31:0] run_hi;
    logic [31:0] run_lo;

    // Select the running unit's completion and result buses
    always_comb begin
        run_done = 1'b0;
        run_hi   = mult_hi;
        run_lo   = mult_lo;
        if (state_q == DIV_RUN) begin
            run_done = div_done && !div_start_q;
            run_hi   = div_hi;
            run_lo   = div_lo;
        end else if (state_q == MULT_RUN) begin
            run_done = mult_done && !mult_start_q;
        end
    end

    // Next-state, counter, HI/LO and output-pulse decode
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        hi_d           = hi_q;
        lo_d           = lo_q;
        mult_start_d   = 1'b0;
        div_start_d    = 1'b0;
        hilo_write_d   = 1'b0;
        div_zero_exc_d = 1'b0;
        timeout_exc_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // Multiply wins when both requests are up.
                if (multOp) begin
                    state_d      = MULT_RUN;
                    cnt_d        = '0;
                    mult_start_d = 1'b1;
                end else if (divOp) begin
                    if (divisor == 32'h0) begin
                        state_d        = EXC;
                        div_zero_exc_d = 1'b1;
                    end else begin
                        state_d     = DIV_RUN;
                        cnt_d       = '0;
                        div_start_d = 1'b1;
                    end
                end
            end

            MULT_RUN, DIV_RUN: begin
                cnt_d = cnt_q + 1'b1;
                // A done on the last allowed cycle still beats the timeout.
                if (run_done) begin
                    state_d      = WRITE;
                    hilo_write_d = 1'b1;
                    hi_d         = run_hi;
                    lo_d         = run_lo;
                end else if (cnt_q == LAST_CNT) begin
                    state_d       = EXC;
                    timeout_exc_d = 1'b1;
                end
            end

            WRITE, EXC: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    // busy follows the registered state so it rises the cycle after accept
    // and stays up through WRITE/EXC.
    assign busy_d = (state_d != IDLE);

    // State, counter, HI/LO and registered outputs; reset overrides all
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            hi_q           <= 32'h0;
            lo_q           <= 32'h0;
            mult_start_q   <= 1'b0;
            div_start_q    <= 1'b0;
            busy_q         <= 1'b0;
            hilo_write_q   <= 1'b0;
            div_zero_exc_q <= 1'b0;
            timeout_exc_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            hi_q           <= hi_d;
            lo_q           <= lo_d;
            mult_start_q   <= mult_start_d;
            div_start_q    <= div_start_d;
            busy_q         <= busy_d;
            hilo_write_q   <= hilo_write_d;
            div_zero_exc_q <= div_zero_exc_d;
            timeout_exc_q  <= timeout_exc_d;
        end
    end

    assign mult_start   = mult_start_q;
    assign div_start    = div_start_q;
    assign busy         = busy_q;
    assign hi_out       = hi_q;
    assign lo_out       = lo_q;
    assign hilo_write   = hilo_write_q;
    assign div_zero_exc = div_zero_exc_q;
    assign timeout_exc  = timeout_exc_q;

endmodule
